// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, angle table and FSM state type for the
// iterative CORDIC sequencer. Table values are stored in Q.16 and rescaled on use.
`default_nettype none

package cordic_pkg;

    localparam int MAX_ITER      = 31;
    localparam int PKG_FRAC_BITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cordic_state_t;

    // round(atan(2^-i) * 2^16); entries beyond 16 round to zero
    localparam logic signed [31:0] ALPHA [MAX_ITER] = '{
        32'sd51472, 32'sd30386, 32'sd16055, 32'sd8150, 32'sd4091,
        32'sd2047,  32'sd1024,  32'sd512,   32'sd256,  32'sd128,
        32'sd64,    32'sd32,    32'sd16,    32'sd8,    32'sd4,
        32'sd2,     32'sd1,     32'sd0,     32'sd0,    32'sd0,
        32'sd0,     32'sd0,     32'sd0,     32'sd0,    32'sd0,
        32'sd0,     32'sd0,     32'sd0,     32'sd0,    32'sd0,
        32'sd0
    };

    localparam logic signed [31:0] K_INIT    = 32'sd39797;
    localparam logic signed [31:0] PI_Q      = 32'sd205887;
    localparam logic signed [31:0] HALF_PI_Q = 32'sd102944;

    function automatic logic signed [31:0] q16_rescale(
        input logic signed [31:0] v,
        input int                 frac
    );
        if (frac >= PKG_FRAC_BITS) begin
            return v <<< (frac - PKG_FRAC_BITS);
        end
        return v >>> (PKG_FRAC_BITS - frac);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic.sv
// cordic: one combinational micro-rotation step in rotation mode; the
// direction follows the sign of the residual angle z.
`default_nettype none

module cordic
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH = 21
) (
    input  logic                          rst,
    input  logic signed [WORD_LENGTH-1:0] x_i,
    input  logic signed [WORD_LENGTH-1:0] y_i,
    input  logic signed [WORD_LENGTH-1:0] z_i,
    input  logic signed [WORD_LENGTH-1:0] alpha_i,
    input  logic        [4:0]             iteration_i,
    output logic signed [WORD_LENGTH-1:0] next_x_o,
    output logic signed [WORD_LENGTH-1:0] next_y_o,
    output logic signed [WORD_LENGTH-1:0] next_z_o
);

    logic signed [WORD_LENGTH-1:0] x_sh;
    logic signed [WORD_LENGTH-1:0] y_sh;

    assign x_sh = x_i >>> iteration_i;
    assign y_sh = y_i >>> iteration_i;

    always_comb begin
        next_x_o = '0;
        next_y_o = '0;
        next_z_o = '0;
        if (!rst) begin
            if (!z_i[WORD_LENGTH-1]) begin
                next_x_o = x_i - y_sh;
                next_y_o = y_i + x_sh;
                next_z_o = z_i - alpha_i;
            end else begin
                next_x_o = x_i + y_sh;
                next_y_o = y_i - x_sh;
                next_z_o = z_i + alpha_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iterative sin/cos sequencer around one shared cordic stage.
// Optional macro CORDIC_QUAD_EXT_EN extends the input range to [-pi, +pi).
`default_nettype none

module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH  = 21,
    parameter int FRAC_BITS    = 16,
    parameter int N_ITERATIONS = 17
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic signed [WORD_LENGTH-1:0] angle_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic signed [WORD_LENGTH-1:0] cos_o,
    output logic signed [WORD_LENGTH-1:0] sin_o,
    output logic                          busy_o
);

    localparam logic [4:0] LAST_ITER = 5'(N_ITERATIONS - 1);
    localparam logic signed [WORD_LENGTH-1:0] K_INIT_W =
        WORD_LENGTH'(q16_rescale(K_INIT, FRAC_BITS));

    cordic_state_t state_q, state_d;
    logic [4:0]    iter_q, iter_d;
    logic signed [WORD_LENGTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WORD_LENGTH-1:0] cos_q, cos_d, sin_q, sin_d;

    logic signed [WORD_LENGTH-1:0] alpha_w;
    logic signed [WORD_LENGTH-1:0] next_x_w, next_y_w, next_z_w;
    logic signed [WORD_LENGTH-1:0] z_load_w;
    logic signed [WORD_LENGTH-1:0] res_x_w, res_y_w;

    assign alpha_w = WORD_LENGTH'(q16_rescale(ALPHA[iter_q], FRAC_BITS));

    cordic #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_stage (
        .rst         (rst),
        .x_i         (x_q),
        .y_i         (y_q),
        .z_i         (z_q),
        .alpha_i     (alpha_w),
        .iteration_i (iter_q),
        .next_x_o    (next_x_w),
        .next_y_o    (next_y_w),
        .next_z_o    (next_z_w)
    );

`ifdef CORDIC_QUAD_EXT_EN
    localparam logic signed [WORD_LENGTH-1:0] PI_W =
        WORD_LENGTH'(q16_rescale(PI_Q, FRAC_BITS));
    localparam logic signed [WORD_LENGTH-1:0] HALF_PI_W =
        WORD_LENGTH'(q16_rescale(HALF_PI_Q, FRAC_BITS));

    logic neg_q;
    logic neg_load_w;

    // Fold outer half-plane angles by pi and negate the result at the end
    always_comb begin
        z_load_w   = angle_i;
        neg_load_w = 1'b0;
        if (angle_i > HALF_PI_W) begin
            z_load_w   = angle_i - PI_W;
            neg_load_w = 1'b1;
        end else if (angle_i < -HALF_PI_W) begin
            z_load_w   = angle_i + PI_W;
            neg_load_w = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (state_q == IDLE && in_valid_i) begin
            neg_q <= neg_load_w;
        end
    end

    assign res_x_w = neg_q ? -next_x_w : next_x_w;
    assign res_y_w = neg_q ? -next_y_w : next_y_w;
`else
    assign z_load_w = angle_i;
    assign res_x_w  = next_x_w;
    assign res_y_w  = next_y_w;
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    x_d     = K_INIT_W;
                    y_d     = '0;
                    z_d     = z_load_w;
                    iter_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d    = next_x_w;
                y_d    = next_y_w;
                z_d    = next_z_w;
                iter_d = iter_q + 5'd1;
                // Result registers capture the final rotation directly
                if (iter_q == LAST_ITER) begin
                    cos_d   = res_x_w;
                    sin_d   = res_y_w;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == RUN) || (state_q == DONE);
    assign cos_o       = cos_q;
    assign sin_o       = sin_q;

endmodule

`default_nettype wire
